// File: rtl/shot_clock_ctrl.sv
`timescale 1ns / 1ps
// Shot-clock sequencing controller: converts referee/game events into load, run and
// one-second tick controls for the BCD shot-clock counter, and drives horn/violation.
module shot_clock_ctrl #(
   parameter int CLK_DIV     = 50000000,
   parameter int HORN_CYCLES = 150000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       poss_change,
   input  logic       offr_reb,
   input  logic [7:0] shot_bcd,
   output logic       load,
   output logic [7:0] load_val,
   output logic       run,
   output logic       tick,
   output logic       horn,
   output logic       violation
);

   // state   | meaning
   // IDLE    | after reset, waiting for the first start
   // RUN     | clock running, prescaler counting, ticks issued
   // STOPPED | clock held, partial second preserved in the prescaler
   // EXPIRED | counter reached 00 while running; horn sounds, waits for reload
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STOPPED = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam int PSC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HORN_W = (HORN_CYCLES > 0) ? $clog2(HORN_CYCLES + 1) : 1;
   localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(CLK_DIV - 1);
   localparam logic [HORN_W-1:0] HORN_LAST = HORN_W'(HORN_CYCLES - 1);
   localparam logic [7:0] BCD_24 = 8'h24;
   localparam logic [7:0] BCD_14 = 8'h14;

   state_t            state;
   logic [PSC_W-1:0]  psc;
   logic [HORN_W-1:0] horn_cnt;
   logic              at_zero;
   logic              below_14;
   logic              psc_wrap;

   assign at_zero  = (shot_bcd == 8'h00);
   // BCD keeps numeric ordering, so a plain binary compare is valid
   assign below_14 = (shot_bcd < BCD_14);
   assign psc_wrap = (psc == PSC_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         psc       <= '0;
         horn_cnt  <= '0;
         load      <= 1'b0;
         load_val  <= BCD_24;
         run       <= 1'b0;
         tick      <= 1'b0;
         horn      <= 1'b0;
         violation <= 1'b0;
      end else begin
         load      <= 1'b0;
         tick      <= 1'b0;
         violation <= 1'b0;

         // horn_cnt holds the remaining high cycles after the current one
         if (horn) begin
            if (horn_cnt == '0) begin
               horn <= 1'b0;
            end else begin
               horn_cnt <= horn_cnt - 1'b1;
            end
         end

         if (poss_change) begin
            load     <= 1'b1;
            load_val <= BCD_24;
            psc      <= '0;
            horn     <= 1'b0;
            horn_cnt <= '0;
            run      <= 1'b0;
            state    <= STOPPED;
         end else if (offr_reb) begin
            if (below_14) begin
               load     <= 1'b1;
               load_val <= BCD_14;
               psc      <= '0;
            end else if (state == RUN) begin
               psc  <= psc_wrap ? '0 : psc + 1'b1;
               tick <= psc_wrap;
            end
            if (state == EXPIRED) begin
               state    <= STOPPED;
               horn     <= 1'b0;
               horn_cnt <= '0;
            end
         end else begin
            unique case (state)
               RUN: begin
                  if (at_zero) begin
                     state     <= EXPIRED;
                     run       <= 1'b0;
                     violation <= 1'b1;
                     horn      <= 1'b1;
                     horn_cnt  <= HORN_LAST;
                  end else if (stop) begin
                     // prescaler frozen so the partial second survives the whistle
                     state <= STOPPED;
                     run   <= 1'b0;
                  end else begin
                     psc  <= psc_wrap ? '0 : psc + 1'b1;
                     tick <= psc_wrap;
                  end
               end
               IDLE, STOPPED: begin
                  if (start && !at_zero) begin
                     state <= RUN;
                     run   <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
`timescale 1ns / 1ps
// Bench for shot_clock_ctrl: closed loop with a behavioural BCD down-counter, a vector
// table, hand-written corner sequences and randomized events checked against a reference model.
module tb_shot_clock_ctrl;
   localparam int CLK_DIV     = 4;
   localparam int HORN_CYCLES = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       poss_change = 1'b0;
   logic       offr_reb = 1'b0;
   logic [7:0] shot_bcd;
   logic       load;
   logic [7:0] load_val;
   logic       run;
   logic       tick;
   logic       horn;
   logic       violation;

   int n_cmp = 0;
   int n_fail = 0;

   shot_clock_ctrl #(.CLK_DIV(CLK_DIV), .HORN_CYCLES(HORN_CYCLES)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .poss_change(poss_change),
      .offr_reb(offr_reb), .shot_bcd(shot_bcd), .load(load), .load_val(load_val),
      .run(run), .tick(tick), .horn(horn), .violation(violation)
   );

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] b);
      int v;
      v = bcd2int(b) - 1;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // downstream shot-clock counter, resets to 24 by itself
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           shot_bcd <= 8'h24;
      else if (load)                      shot_bcd <= load_val;
      else if (tick && shot_bcd != 8'h00) shot_bcd <= bcd_dec(shot_bcd);
   end

   // reference model: modes, fraction of a second elapsed, horn cycles remaining
   localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_EXP = 3;
   int         m_mode = M_IDLE;
   int         m_phase = 0;
   int         m_horn_left = 0;
   int         m_v;
   logic       e_load = 1'b0, e_run = 1'b0, e_tick = 1'b0, e_viol = 1'b0, e_horn = 1'b0;
   logic [7:0] e_lv = 8'h24;

   task m_advance();
      m_phase = (m_phase + 1) % CLK_DIV;
      e_tick  = (m_phase == 0);
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = M_IDLE; m_phase = 0; m_horn_left = 0;
         e_load = 1'b0; e_lv = 8'h24; e_run = 1'b0; e_tick = 1'b0; e_viol = 1'b0; e_horn = 1'b0;
      end else begin
         e_load = 1'b0; e_tick = 1'b0; e_viol = 1'b0;
         if (m_horn_left > 0) m_horn_left = m_horn_left - 1;
         m_v = bcd2int(shot_bcd);
         if (poss_change) begin
            e_load = 1'b1; e_lv = 8'h24; m_phase = 0; m_horn_left = 0; m_mode = M_STOP;
         end else if (offr_reb) begin
            if (m_v < 14) begin
               e_load = 1'b1; e_lv = 8'h14; m_phase = 0;
            end else if (m_mode == M_RUN) begin
               m_advance();
            end
            if (m_mode == M_EXP) begin
               m_mode = M_STOP; m_horn_left = 0;
            end
         end else if (m_mode == M_RUN && m_v == 0) begin
            m_mode = M_EXP; e_viol = 1'b1; m_horn_left = HORN_CYCLES;
         end else if (m_mode == M_RUN && stop) begin
            m_mode = M_STOP;
         end else if (start && (m_mode == M_IDLE || m_mode == M_STOP) && m_v != 0) begin
            m_mode = M_RUN;
         end else if (m_mode == M_RUN) begin
            m_advance();
         end
         e_run  = (m_mode == M_RUN);
         e_horn = (m_horn_left > 0);
      end
   end

   function automatic logic [12:0] outs();
      return {load, load_val, run, tick, horn, violation};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic sp, input logic pc, input logic ob);
      start = s; stop = sp; poss_change = pc; offr_reb = ob;
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; poss_change = 1'b0; offr_reb = 1'b0;
      chk("model", 32'(outs()), 32'({e_load, e_lv, e_run, e_tick, e_horn, e_viol}));
   endtask

   typedef struct {
      logic       start, stop, poss, offr;
      logic       load;
      logic [7:0] load_val;
      logic       run, tick, horn, viol;
   } vec_t;

   function automatic vec_t mk(input logic s, sp, pc, ob, ld, input logic [7:0] lv,
                               input logic rn, tk);
      vec_t v;
      v.start = s; v.stop = sp; v.poss = pc; v.offr = ob;
      v.load = ld; v.load_val = lv; v.run = rn; v.tick = tk; v.horn = 1'b0; v.viol = 1'b0;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[25];
      int   k, t, last, nticks, hcnt;
      logic bad, seen_load;

      tbl[0]  = mk(0,0,0,0, 0,8'h24,0,0);
      tbl[1]  = mk(0,1,0,0, 0,8'h24,0,0);
      tbl[2]  = mk(0,0,0,1, 0,8'h24,0,0);
      tbl[3]  = mk(1,0,0,0, 0,8'h24,1,0);
      tbl[4]  = mk(1,0,0,0, 0,8'h24,1,0);
      tbl[5]  = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[6]  = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[7]  = mk(0,0,0,0, 0,8'h24,1,1);
      tbl[8]  = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[9]  = mk(0,0,0,1, 0,8'h24,1,0);
      tbl[10] = mk(0,1,0,0, 0,8'h24,0,0);
      tbl[11] = mk(0,0,1,0, 1,8'h24,0,0);
      tbl[12] = mk(0,0,0,0, 0,8'h24,0,0);
      tbl[13] = mk(0,0,0,1, 0,8'h24,0,0);
      tbl[14] = mk(1,0,0,0, 0,8'h24,1,0);
      tbl[15] = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[16] = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[17] = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[18] = mk(0,0,0,0, 0,8'h24,1,1);
      tbl[19] = mk(0,1,1,0, 1,8'h24,0,0);
      tbl[20] = mk(1,0,0,0, 0,8'h24,1,0);
      tbl[21] = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[22] = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[23] = mk(0,0,0,0, 0,8'h24,1,0);
      tbl[24] = mk(0,0,0,0, 0,8'h24,1,1);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_load", 32'(load), 0);
      chk("rst_load_val", 32'(load_val), 32'h24);
      chk("rst_run", 32'(run), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_horn", 32'(horn), 0);
      chk("rst_violation", 32'(violation), 0);
      rst = 1'b1;

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].start, tbl[i].stop, tbl[i].poss, tbl[i].offr);
         chk($sformatf("vec%0d", i), 32'(outs()),
             32'({tbl[i].load, tbl[i].load_val, tbl[i].run, tbl[i].tick, tbl[i].horn, tbl[i].viol}));
      end

      // run from 24 down through 19 with a tick every CLK_DIV cycles
      step(0,0,1,0);
      step(0,0,0,0);
      step(1,0,0,0);
      chk("t1_run", 32'(run), 1);
      t = 0; last = 0; nticks = 0; bad = 1'b0; seen_load = 1'b0;
      while (shot_bcd != 8'h19 && t < 40) begin
         step(0,0,0,0);
         t++;
         if (load) seen_load = 1'b1;
         if (tick) begin
            if (t - last != CLK_DIV) bad = 1'b1;
            last = t;
            nticks++;
         end
      end
      chk("t1_count_19", 32'(shot_bcd), 32'h19);
      chk("t1_tick_spacing", 32'(bad), 0);
      chk("t1_tick_count", 32'(nticks), 5);
      chk("t1_no_load", 32'(seen_load), 0);

      // expiry: one-cycle violation, horn for HORN_CYCLES, start ignored
      k = 0;
      while (!violation && k < 200) begin step(0,0,0,0); k++; end
      chk("t2_violation", 32'(violation), 1);
      chk("t2_counter_zero", 32'(shot_bcd), 0);
      chk("t2_run_low", 32'(run), 0);
      chk("t2_horn_on", 32'(horn), 1);
      hcnt = 1;
      step(1,0,0,0);
      chk("t2_violation_one_cycle", 32'(violation), 0);
      chk("t2_start_ignored", 32'(run), 0);
      if (horn) hcnt++;
      k = 0;
      while (horn && k < 10) begin step(0,0,0,0); if (horn) hcnt++; k++; end
      chk("t2_horn_length", 32'(hcnt), HORN_CYCLES);
      chk("t2_still_expired", 32'(run), 0);

      // offensive rebound reloads 14 only below 14
      step(0,0,0,1);
      chk("t3_exp_reb_load", 32'(load), 1);
      chk("t3_exp_reb_val", 32'(load_val), 32'h14);
      step(0,0,0,0);
      step(1,0,0,0);
      chk("t3_restart", 32'(run), 1);
      k = 0;
      while (shot_bcd != 8'h09 && k < 100) begin step(0,0,0,0); k++; end
      chk("t3_at_09", 32'(shot_bcd), 32'h09);
      step(0,0,0,1);
      chk("t3_reb_09_load", 32'(load), 1);
      chk("t3_reb_09_val", 32'(load_val), 32'h14);
      chk("t3_reb_09_run", 32'(run), 1);
      step(0,0,1,0);
      step(0,0,0,0);
      step(1,0,0,0);
      k = 0;
      while (shot_bcd != 8'h17 && k < 60) begin step(0,0,0,0); k++; end
      chk("t3_at_17", 32'(shot_bcd), 32'h17);
      step(0,0,0,1);
      chk("t3_reb_17_noload", 32'(load), 0);
      chk("t3_reb_17_run", 32'(run), 1);

      // stop with prescaler at 2, resume: tick two cycles after run rises
      k = 0;
      while (!tick && k < 10) begin step(0,0,0,0); k++; end
      chk("t4_tick_seen", 32'(tick), 1);
      step(0,0,0,0);
      step(0,0,0,0);
      step(0,1,0,0);
      chk("t4_stopped", 32'(run), 0);
      repeat (10) step(0,0,0,0);
      step(1,0,0,0);
      chk("t4_resumed", 32'(run), 1);
      k = 0;
      do begin step(0,0,0,0); k++; end while (!tick && k < 8);
      chk("t4_partial_second", 32'(k), 2);

      // possession change in the same cycle the counter reads 00
      step(0,0,1,0);
      step(0,0,0,0);
      step(1,0,0,0);
      k = 0;
      while (shot_bcd != 8'h00 && k < 150) begin step(0,0,0,0); k++; end
      chk("t6_zero_running", 32'(run), 1);
      step(0,0,1,0);
      chk("t6_load", 32'(load), 1);
      chk("t6_load_val", 32'(load_val), 32'h24);
      chk("t6_no_violation", 32'(violation), 0);
      chk("t6_no_horn", 32'(horn), 0);
      chk("t6_run_low", 32'(run), 0);

      // asynchronous reset while the horn sounds
      step(0,0,0,0);
      step(1,0,0,0);
      k = 0;
      while (!violation && k < 150) begin step(0,0,0,0); k++; end
      chk("t6_expired_again", 32'(violation), 1);
      step(0,0,0,0);
      chk("t6_horn_before_rst", 32'(horn), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_horn", 32'(horn), 0);
      chk("t6_rst_run", 32'(run), 0);
      chk("t6_rst_load_val", 32'(load_val), 32'h24);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1,0,0,0);
      chk("t6_idle_start", 32'(run), 1);

      // randomized event streams against the reference model
      for (int i = 0; i < 2500; i++)
         step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 399) == 0, $urandom_range(0, 59) == 0);
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0,
              $urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/shot_clock_ctrl.md
# shot_clock_ctrl

Sequencing controller for the 24-second shot clock counter. Turns referee/game events (start, whistle, possession change, offensive rebound) into load, run and one-second tick controls for the downstream two-digit BCD shot-clock counter. Detects expiry from the counter's displayed value and drives the horn and violation flag. Sits between the scoreboard event inputs and the shot-clock counter/display path.

## Interface

- CLK_DIV, default 50000000: clk cycles per one-second tick; must be ≥ 2.
- HORN_CYCLES, default 150000000: horn duration in clk cycles; must be ≥ 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; referee starts the clock.
- stop  in  1  single-cycle pulse; whistle stops the clock.
- poss_change  in  1  single-cycle pulse; new possession, reload 24.
- offr_reb  in  1  single-cycle pulse; offensive rebound, reload 14 if below 14.
- shot_bcd  in  8  current counter value, BCD {tens, ones}.
- load  out  1  single-cycle pulse; counter loads load_val.
- load_val  out  8  BCD value to load; valid when load=1.
- run  out  1  counter enable; high only in RUN.
- tick  out  1  single-cycle decrement strobe; only asserted while run=1.
- horn  out  1  horn drive.
- violation  out  1  single-cycle pulse on entry to EXPIRED.

## Operation

- States: IDLE, RUN, STOPPED, EXPIRED. Reset enters IDLE. Downstream counter resets to 24 on its own, so reset issues no load.
- Reset values: load=0, load_val=8'h24, run=0, tick=0, horn=0, violation=0, prescaler=0, horn counter=0.
- Event priority within one cycle: poss_change > offr_reb > expiry > stop > start. Only the highest-priority event takes effect that cycle.
- poss_change, any state: load=1, load_val=8'h24, prescaler cleared, horn cleared. Next state STOPPED.
- offr_reb, any state:
  - If shot_bcd < 8'h14 (plain 8-bit compare; valid because BCD preserves ordering): load=1, load_val=8'h14, prescaler cleared.
  - Otherwise no load.
  - From EXPIRED, go to STOPPED and clear the horn. Other states are unchanged.
- start in IDLE or STOPPED:
  - Go to RUN if shot_bcd != 0.
  - If shot_bcd == 0, ignore.
  - Ignored in RUN and EXPIRED.
- stop in RUN: go to STOPPED. Ignored elsewhere.
- Expiry: in RUN with shot_bcd == 8'h00, go to EXPIRED.
  - violation=1 for one cycle.
  - horn=1 for exactly HORN_CYCLES cycles, then 0.
  - EXPIRED holds until poss_change or offr_reb.
  - start and stop are ignored in EXPIRED.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUN.
  - Holds its value in IDLE, STOPPED and EXPIRED, so a stopped partial second is preserved.
  - Cleared on every load.
  - tick=1 in the cycle the prescaler equals CLK_DIV-1 while in RUN; the prescaler wraps to 0 in that cycle.
- Internal widths: prescaler $clog2(CLK_DIV) bits; horn counter $clog2(HORN_CYCLES+1) bits.

## Timing

- All outputs are registered and change on the clk edge after the causing input is sampled.
- Event pulse at edge N: load/load_val and the new run value are visible after edge N+1. Counter loads at edge N+2.
- run rises after the edge that samples start. The first tick comes CLK_DIV cycles after run rises, provided the prescaler was 0.
- Expiry at edge N (shot_bcd==0 sampled in RUN):
  - run=0, violation=1 and horn=1 after edge N+1.
  - violation clears after N+2.
  - horn clears after N+1+HORN_CYCLES.
- A tick may be issued in the same cycle the counter reaches 0. No further tick follows because run drops.
- poss_change in the same cycle as expiry: load 24, go to STOPPED, no violation, no horn.
- Asynchronous reset mid-operation forces all reset values immediately, including clearing an active horn.

## Test plan

Bench uses CLK_DIV=4 and HORN_CYCLES=3, with a behavioural BCD down-counter driven by load/tick.

1. Reset, then start → run=1; ticks every 4 cycles; counter 24→23→…→20→19. No load seen.
2. Run to 00 → one-cycle violation; horn high exactly 3 cycles; run=0; start ignored while EXPIRED.
3. With counter at 09 and RUN, pulse offr_reb → load=1 with load_val=8'h14; state unchanged (still RUN). With counter at 17, offr_reb → no load.
4. stop at prescaler=2, wait 10 cycles, then start → next tick exactly 2 cycles after run rises (partial second preserved).
5. poss_change and stop in the same cycle while RUN → load 24; state STOPPED; prescaler 0.
6. poss_change in the same cycle the counter reaches 00 → no violation, no horn, load 24. Async rst asserted during horn → horn=0 immediately; state IDLE.
